mem_req_arbiter: RTL
====================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of requestor ports (icache, dcache, vector load/store units); legal range 2..8.
REQ-002 Parameter FIFO_DEPTH, default 4: depth of the output request queue; power of two, at least 2.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_in[NUM_PORTS]  input  request_t each  per-port memory request; a request is valid when .vld=1.
REQ-006 req_grant[NUM_PORTS]  output  1 each  combinational acceptance of req_in[i] in the current cycle.
REQ-007 mem_req  output  request_t  head of the output queue toward memory.
REQ-008 mem_ready  input  1  memory accepts mem_req this cycle.
REQ-009 mem_rsp  input  request_t  memory response; routed by .core_id.
REQ-010 rsp_out[NUM_PORTS]  output  request_t each  registered per-port response.
REQ-011 route_err  output  1  sticky flag; set by a valid response whose core_id is at or above NUM_PORTS.
REQ-012 occupancy  output  $clog2(FIFO_DEPTH)+1  current queue fill level.

Function
REQ-013 A transfer on port i SHALL occur in every cycle where req_in[i].vld and req_grant[i] are both 1.
- The requestor may present its next request in the following cycle.
REQ-014 At most one req_grant bit SHALL be 1 per cycle.
- req_grant SHALL be all-zero when occupancy == FIFO_DEPTH.
- Full is evaluated before the same-cycle pop: there is no combinational path from mem_ready to req_grant.
REQ-015 Arbitration SHALL be round-robin using a pointer rr_ptr.
- Search starts at rr_ptr and proceeds upward, wrapping modulo NUM_PORTS.
- The first valid port found is granted.
REQ-016 After a grant to port k, rr_ptr SHALL become (k+1) mod NUM_PORTS.
- rr_ptr SHALL NOT change in cycles with no grant.
REQ-017 The granted request SHALL be written unmodified (all fields) into the queue tail in the same cycle.
REQ-018 mem_req SHALL equal the queue head entry with .vld=1 when occupancy > 0.
- mem_req SHALL be all-zero when the queue is empty.
- Latency from grant to mem_req.vld is one cycle when the queue was empty.
REQ-019 The head SHALL be popped when mem_req.vld and mem_ready are both 1.
REQ-020 Occupancy update rules:
- Push and pop in the same cycle leave occupancy unchanged.
- Push only: +1.
- Pop only: -1.
- Read and write pointers wrap modulo FIFO_DEPTH.
REQ-021 Requests SHALL leave the queue in grant order.
- No reordering.
- No drop.
REQ-022 Response routing, per cycle, when mem_rsp.vld=1 and mem_rsp.core_id == k < NUM_PORTS:
- rsp_out[k] SHALL be loaded with mem_rsp in the next cycle.
- All other rsp_out[j] SHALL have .vld=0 in that cycle.
- Response latency is exactly one cycle and responses are never back-pressured.
REQ-023 When mem_rsp.vld=1 and core_id >= NUM_PORTS:
- The response SHALL be dropped.
- route_err SHALL be set and remain 1 until reset.
REQ-024 rsp_out[j] SHALL be all-zero in any cycle not carrying a routed response.
REQ-025 access_id and access_length SHALL pass through unchanged in both directions.
- A multi-beat cache line fill is carried as independent single-beat requests.

Reset
REQ-026 Assertion of reset at any time, including with a non-empty queue, SHALL clear the following immediately:
- the queue, with occupancy=0;
- rr_ptr to 0;
- mem_req to 0;
- every rsp_out to 0;
- route_err to 0.
Queued requests are discarded.
REQ-027 While reset is asserted, req_grant SHALL be all-zero.
REQ-028 The first grant after deassertion SHALL favour port 0.

Verification
REQ-029 Ports 0..3 all valid after reset, mem_ready=1 -> grants in order 0,1,2,3,0, one per cycle; mem_req order matches; occupancy stays at most 1.
REQ-030 Port 1 only, holding 5 requests (addr 0x40..0x44), mem_ready=0 -> 4 grants, then req_grant=0 with occupancy=4; mem_ready=1 for one cycle -> occupancy 3, then the 5th request is granted the next cycle.
REQ-031 Full queue with simultaneous pop and requests pending -> no grant that cycle; grant resumes next cycle; addr order is preserved end to end.
REQ-032 mem_rsp vld, core_id=2, access_id=0x40, data=0xDEAD -> next cycle rsp_out[2] carries those fields; rsp_out[0,1,3].vld=0.
REQ-033 mem_rsp vld, core_id=7 with NUM_PORTS=4 -> no rsp_out valid; route_err=1 until reset.
REQ-034 Reset asserted with occupancy=3 -> mem_req=0, occupancy=0, rr_ptr=0 immediately; after release, ports 2 and 0 valid -> port 0 granted first.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter funnelling per-port memory requests into one ordered queue, with response fan-out.
// Latency: grant to mem_req.vld is 1 cycle when the queue is empty; mem_rsp to rsp_out is 1 cycle.
// Backpressure: no port is granted while the queue is full; mem_ready stalls the head; responses never stall.

package mem_req_arbiter_pkg;
  typedef struct packed {
    logic        vld;
    logic [3:0]  core_id;
    logic [7:0]  access_id;
    logic [3:0]  access_length;
    logic [31:0] addr;
    logic [31:0] data;
  } request_t;
endpackage

module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  request_t                      req_in [NUM_PORTS],
  output logic [NUM_PORTS-1:0]          req_grant,
  output request_t                      mem_req,
  input  logic                          mem_ready,
  input  request_t                      mem_rsp,
  output request_t                      rsp_out [NUM_PORTS],
  output logic                          route_err,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt_idx;
  logic          gnt_found;
  logic          full;
  logic          push;
  logic          pop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  request_t      fifo_mem [FIFO_DEPTH];

  // Fullness uses the registered fill level only, so mem_ready never reaches req_grant.
  assign full = (occupancy == CW'(FIFO_DEPTH));
  assign push = |req_grant;
  assign pop  = (occupancy != '0) && mem_ready;

  // Round-robin search: first valid port at or above rr_ptr, wrapping.
  always_comb begin
    int            cand;
    logic [PW-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    req_grant = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      cand = int'(rr_ptr) + off;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = PW'(cand);
      if (!gnt_found && req_in[cand_idx].vld) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
    if (reset && !full && gnt_found) req_grant[gnt_idx] = 1'b1;
  end

  // Pointer, fill-level and round-robin state; reset discards queued requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rr_ptr <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Queue storage; the granted request is stored exactly as presented.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= req_in[gnt_idx];
  end

  // Head presentation: all-zero when empty so stale entries never leak out.
  always_comb begin
    mem_req = '0;
    if (occupancy != '0) begin
      mem_req     = fifo_mem[rd_ptr];
      mem_req.vld = 1'b1;
    end
  end

  // Response fan-out by core_id; unroutable responses are dropped and flagged until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < NUM_PORTS; j++) rsp_out[j] <= '0;
      route_err <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        rsp_out[j] <= (mem_rsp.vld && int'(mem_rsp.core_id) == j) ? mem_rsp : '0;
      end
      if (mem_rsp.vld && int'(mem_rsp.core_id) >= NUM_PORTS) route_err <= 1'b1;
    end
  end

endmodule
